// File: rtl/pip_wb_arbiter_if.sv
// Write-back bus bundle between the stage-4 pipeline, the secondary unit and the register file.
// Pipeline and secondary-unit requests enter the arbiter; register-file write, scoreboard and status leave it.
// slave modport: arbiter side; master modport: the surrounding pipeline / environment.
interface pip_wb_arbiter_if #(
    parameter int AW    = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    // pipeline write-back (stage-4 register)
    logic              p_wen;
    logic [AW-1:0]     p_addr;
    logic [DW-1:0]     p_data;
    // secondary result stream
    logic              s_valid;
    logic              s_ready;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_data;
    // multi-cycle op issue (scoreboard set)
    logic              s_issue;
    logic [AW-1:0]     s_issue_addr;
    // status
    logic [(1<<AW)-1:0] busy;
    logic [CW-1:0]     fifo_count;
    logic              waw_err;
    // register-file write port
    logic              rf_wen;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;

    modport slave (
        input  p_wen, p_addr, p_data,
        input  s_valid, s_addr, s_data,
        input  s_issue, s_issue_addr,
        output s_ready, busy, fifo_count, waw_err,
        output rf_wen, rf_waddr, rf_wdata
    );

    modport master (
        output p_wen, p_addr, p_data,
        output s_valid, s_addr, s_data,
        output s_issue, s_issue_addr,
        input  s_ready, busy, fifo_count, waw_err,
        input  rf_wen, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/pip_wb_arbiter.sv
// Shares the register-file write port between the pipeline (top priority) and a FIFO-buffered secondary unit.
// Latency: pipeline write 1 cycle; secondary entry >=2 cycles after push, longer while p_wen stays high.
// Backpressure: pipeline never stalls; secondary sees s_ready=0 while the FIFO is full (a same-cycle pop does not free room).
//
// Ports: clk, rst (sync, active-high) plus bus (pip_wb_arbiter_if.slave) carrying the pipeline write,
// the secondary valid/ready stream, the issue/scoreboard signals and the registered register-file write.
// Optional feature macro WB_R0_ZERO_EN: register 0 is hard-wired (no writes, never busy, no waw_err).
module pip_wb_arbiter #(
    parameter int AW    = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    pip_wb_arbiter_if.slave   bus
);
    localparam int NR = 1 << AW;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

`ifdef WB_R0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    // ---------------- secondary FIFO ----------------
    logic [AW+DW-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic             push;
    logic             fifo_rdy;
    logic             fifo_vld;
    logic             grant_s;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_data;

    // Ready looks only at occupancy, so a pop in the same cycle never makes room.
    assign fifo_rdy  = (count != CW'(DEPTH));
    assign fifo_vld  = (count != '0);
    assign push      = bus.s_valid && fifo_rdy;
    assign grant_s   = fifo_vld && !bus.p_wen;
    assign {head_addr, head_data} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.s_addr, bus.s_data};
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their natural width.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (grant_s) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(grant_s);
        end
    end

    assign bus.s_ready    = fifo_rdy;
    assign bus.fifo_count = count;

    // ---------------- register-0 masking ----------------
    logic p_r0;
    logic h_r0;
    logic i_r0;

    assign p_r0 = R0_ZERO && (bus.p_addr == '0);
    assign h_r0 = R0_ZERO && (head_addr == '0);
    assign i_r0 = R0_ZERO && (bus.s_issue_addr == '0);

    // ---------------- scoreboard ----------------
    logic [NR-1:0] busy_q;
    logic [NR-1:0] busy_nxt;

    // Clear first, then set, so an issue to the address being retired keeps it busy.
    always_comb begin
        busy_nxt = busy_q;
        if (grant_s) begin
            busy_nxt[head_addr] = 1'b0;
        end
        if (bus.s_issue && !i_r0) begin
            busy_nxt[bus.s_issue_addr] = 1'b1;
        end
    end

    // ---------------- write port ----------------
    logic          rf_wen_q;
    logic [AW-1:0] rf_waddr_q;
    logic [DW-1:0] rf_wdata_q;
    logic          waw_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
            waw_q      <= 1'b0;
        end else begin
            busy_q <= busy_nxt;
            // A pipeline write to a pending register means the hazard unit failed to stall;
            // flag it but still perform the write.
            waw_q  <= bus.p_wen && busy_q[bus.p_addr] && !p_r0;
            if (bus.p_wen) begin
                rf_wen_q   <= !p_r0;
                rf_waddr_q <= bus.p_addr;
                rf_wdata_q <= bus.p_data;
            end else if (grant_s) begin
                rf_wen_q   <= !h_r0;
                rf_waddr_q <= head_addr;
                rf_wdata_q <= head_data;
            end else begin
                rf_wen_q   <= 1'b0;
            end
        end
    end

    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.busy     = busy_q;
    assign bus.waw_err  = waw_q;
endmodule

// File: tb/tb_pip_wb_arbiter.sv
// Bench for pip_wb_arbiter: vector table, hand-written corner sequences and random traffic vs a queue model.
// Inputs are driven 1 time unit after the rising edge; outputs are compared 1 time unit after the next edge.
// Register-0 expectations follow WB_R0_ZERO_EN when it is defined for the build.
module tb_pip_wb_arbiter;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

`ifdef WB_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pip_wb_arbiter_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

    pip_wb_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        p_wen;
        logic [3:0]  p_addr;
        logic [15:0] p_data;
        logic        s_valid;
        logic [3:0]  s_addr;
        logic [15:0] s_data;
        logic        s_issue;
        logic [3:0]  s_issue_addr;
    } in_t;

    typedef struct {
        logic        wen;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        logic [15:0] busy;
        logic [2:0]  cnt;
        logic        rdy;
        logic        waw;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } ent_t;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    ent_t        mq[$];
    logic [15:0] mbusy;
    out_t        m;

    function automatic in_t mk_in(logic r, logic pw, logic [3:0] pa, logic [15:0] pd,
                                  logic sv, logic [3:0] sa, logic [15:0] sd,
                                  logic si, logic [3:0] sia);
        in_t i;
        i.rst = r; i.p_wen = pw; i.p_addr = pa; i.p_data = pd;
        i.s_valid = sv; i.s_addr = sa; i.s_data = sd;
        i.s_issue = si; i.s_issue_addr = sia;
        return i;
    endfunction

    function automatic out_t mk_out(logic w, logic [3:0] a, logic [15:0] d, logic [15:0] b,
                                    logic [2:0] c, logic r, logic e);
        out_t o;
        o.wen = w; o.waddr = a; o.wdata = d; o.busy = b; o.cnt = c; o.rdy = r; o.waw = e;
        return o;
    endfunction

    function automatic in_t idle();
        return mk_in(1'b0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
    endfunction

    // One clock of the architectural rules: pipeline first, else oldest queued result;
    // room is judged on occupancy before the pop.
    task automatic model_step(input in_t i);
        ent_t e;
        bit   room;
        if (i.rst) begin
            mq.delete();
            mbusy = '0;
            m = mk_out(1'b0, 4'h0, 16'h0, 16'h0, 3'd0, 1'b1, 1'b0);
            return;
        end
        room  = (mq.size() != DEPTH);
        m.waw = i.p_wen && mbusy[i.p_addr] && !(R0Z && i.p_addr == 4'h0);
        if (i.p_wen) begin
            m.wen   = !(R0Z && i.p_addr == 4'h0);
            m.waddr = i.p_addr;
            m.wdata = i.p_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            m.wen   = !(R0Z && e.addr == 4'h0);
            m.waddr = e.addr;
            m.wdata = e.data;
            mbusy[e.addr] = 1'b0;
        end else begin
            m.wen = 1'b0;
        end
        if (i.s_issue && !(R0Z && i.s_issue_addr == 4'h0)) begin
            mbusy[i.s_issue_addr] = 1'b1;
        end
        if (i.s_valid && room) begin
            e.addr = i.s_addr;
            e.data = i.s_data;
            mq.push_back(e);
        end
        m.busy = mbusy;
        m.cnt  = 3'(mq.size());
        m.rdy  = (mq.size() != DEPTH);
    endtask

    // ---------------- drive / check ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input out_t e);
        chk({tag, ".rf_wen"},     32'(bus.rf_wen),     32'(e.wen));
        chk({tag, ".rf_waddr"},   32'(bus.rf_waddr),   32'(e.waddr));
        chk({tag, ".rf_wdata"},   32'(bus.rf_wdata),   32'(e.wdata));
        chk({tag, ".busy"},       32'(bus.busy),       32'(e.busy));
        chk({tag, ".fifo_count"}, 32'(bus.fifo_count), 32'(e.cnt));
        chk({tag, ".s_ready"},    32'(bus.s_ready),    32'(e.rdy));
        chk({tag, ".waw_err"},    32'(bus.waw_err),    32'(e.waw));
    endtask

    task automatic step(input in_t i);
        rst              = i.rst;
        bus.p_wen        = i.p_wen;
        bus.p_addr       = i.p_addr;
        bus.p_data       = i.p_data;
        bus.s_valid      = i.s_valid;
        bus.s_addr       = i.s_addr;
        bus.s_data       = i.s_data;
        bus.s_issue      = i.s_issue;
        bus.s_issue_addr = i.s_issue_addr;
        model_step(i);
        @(posedge clk);
        #1;
    endtask

    vec_t vt[$];
    logic [3:0] full_addr [4];

    initial begin
        in_t  i;
        vec_t v;

        full_addr[0] = 4'd2; full_addr[1] = 4'd6; full_addr[2] = 4'd10; full_addr[3] = 4'd14;

        // ---- reset: two cycles ----
        i = idle(); i.rst = 1'b1;
        step(i);
        step(i);
        chk_out("reset", mk_out(1'b0, 4'h0, 16'h0, 16'h0, 3'd0, 1'b1, 1'b0));

        // ---- vector table: pipeline write, contention, WAW, mid-run reset ----
        v.in = mk_in(0,1,4'd3,16'hBEEF, 0,4'd0,16'h0, 0,4'd0); v.exp = mk_out(1,4'd3,16'hBEEF,16'h0000,3'd0,1,0); vt.push_back(v);
        v.in = mk_in(0,0,4'd0,16'h0,    0,4'd0,16'h0, 0,4'd0); v.exp = mk_out(0,4'd3,16'hBEEF,16'h0000,3'd0,1,0); vt.push_back(v);
        v.in = mk_in(0,0,4'd0,16'h0,    0,4'd0,16'h0, 1,4'd5); v.exp = mk_out(0,4'd3,16'hBEEF,16'h0020,3'd0,1,0); vt.push_back(v);
        v.in = mk_in(0,1,4'd1,16'h1111, 1,4'd5,16'h1234, 0,4'd0); v.exp = mk_out(1,4'd1,16'h1111,16'h0020,3'd1,1,0); vt.push_back(v);
        v.in = mk_in(0,1,4'd2,16'h2222, 0,4'd0,16'h0, 0,4'd0); v.exp = mk_out(1,4'd2,16'h2222,16'h0020,3'd1,1,0); vt.push_back(v);
        v.in = mk_in(0,1,4'd4,16'h4444, 0,4'd0,16'h0, 0,4'd0); v.exp = mk_out(1,4'd4,16'h4444,16'h0020,3'd1,1,0); vt.push_back(v);
        v.in = mk_in(0,0,4'd0,16'h0,    0,4'd0,16'h0, 0,4'd0); v.exp = mk_out(1,4'd5,16'h1234,16'h0000,3'd0,1,0); vt.push_back(v);
        v.in = mk_in(0,0,4'd0,16'h0,    0,4'd0,16'h0, 0,4'd0); v.exp = mk_out(0,4'd5,16'h1234,16'h0000,3'd0,1,0); vt.push_back(v);
        v.in = mk_in(0,0,4'd0,16'h0,    0,4'd0,16'h0, 1,4'd7); v.exp = mk_out(0,4'd5,16'h1234,16'h0080,3'd0,1,0); vt.push_back(v);
        v.in = mk_in(0,1,4'd7,16'h7777, 0,4'd0,16'h0, 0,4'd0); v.exp = mk_out(1,4'd7,16'h7777,16'h0080,3'd0,1,1); vt.push_back(v);
        v.in = mk_in(0,0,4'd0,16'h0,    0,4'd0,16'h0, 0,4'd0); v.exp = mk_out(0,4'd7,16'h7777,16'h0080,3'd0,1,0); vt.push_back(v);
        v.in = mk_in(0,1,4'd1,16'h5555, 1,4'd3,16'h3333, 1,4'd9); v.exp = mk_out(1,4'd1,16'h5555,16'h0280,3'd1,1,0); vt.push_back(v);
        v.in = mk_in(1,1,4'd2,16'h6666, 0,4'd0,16'h0, 0,4'd0); v.exp = mk_out(0,4'd0,16'h0000,16'h0000,3'd0,1,0); vt.push_back(v);
        v.in = mk_in(0,0,4'd0,16'h0,    0,4'd0,16'h0, 0,4'd0); v.exp = mk_out(0,4'd0,16'h0000,16'h0000,3'd0,1,0); vt.push_back(v);

        for (int k = 0; k < vt.size(); k++) begin
            step(vt[k].in);
            chk_out($sformatf("vec%0d", k), vt[k].exp);
        end

        // ---- full FIFO with pipeline holding the port ----
        for (int k = 0; k < DEPTH; k++) begin
            step(mk_in(0, 1, 4'd9, 16'h9000 + 16'(k), 1, full_addr[k], 16'hA000 + 16'(k), 0, 4'd0));
            chk("full.fill_count", 32'(bus.fifo_count), 32'(k + 1));
        end
        chk("full.s_ready", 32'(bus.s_ready), 32'd0);
        // Push attempt while full is refused.
        step(mk_in(0, 1, 4'd9, 16'h9999, 1, 4'd15, 16'hDEAD, 0, 4'd0));
        chk("full.refused_count", 32'(bus.fifo_count), 32'd4);
        // Pop while full with s_valid high: pop happens, push still refused.
        step(mk_in(0, 0, 4'd0, 16'h0, 1, 4'd15, 16'hDEAD, 0, 4'd0));
        chk("full.pop_no_room_count", 32'(bus.fifo_count), 32'd3);
        chk("full.drain0_addr", 32'(bus.rf_waddr), 32'(full_addr[0]));
        chk("full.drain0_data", 32'(bus.rf_wdata), 32'hA000);
        for (int k = 1; k < DEPTH; k++) begin
            step(idle());
            chk($sformatf("full.drain%0d_wen", k),  32'(bus.rf_wen),   32'd1);
            chk($sformatf("full.drain%0d_addr", k), 32'(bus.rf_waddr), 32'(full_addr[k]));
            chk($sformatf("full.drain%0d_data", k), 32'(bus.rf_wdata), 32'hA000 + 32'(k));
        end
        step(idle());
        chk("full.after_drain_wen",   32'(bus.rf_wen),     32'd0);
        chk("full.after_drain_count", 32'(bus.fifo_count), 32'd0);
        chk("full.after_drain_hold",  32'(bus.rf_wdata),   32'hA003);

        // ---- register 0 ----
        step(mk_in(0, 1, 4'd0, 16'h0F0F, 0, 4'd0, 16'h0, 0, 4'd0));
        chk("r0.pipe_wen",   32'(bus.rf_wen),   R0Z ? 32'd0 : 32'd1);
        chk("r0.pipe_waddr", 32'(bus.rf_waddr), 32'd0);
        step(mk_in(0, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 1, 4'd0));
        chk("r0.issue_busy", 32'(bus.busy), R0Z ? 32'd0 : 32'd1);
        step(mk_in(0, 1, 4'd0, 16'h0001, 0, 4'd0, 16'h0, 0, 4'd0));
        chk("r0.waw", 32'(bus.waw_err), R0Z ? 32'd0 : 32'd1);
        // Secondary entry to r0 is still popped.
        step(mk_in(0, 1, 4'd8, 16'h0008, 1, 4'd0, 16'hC0C0, 0, 4'd0));
        step(idle());
        chk("r0.fifo_wen",   32'(bus.rf_wen),     R0Z ? 32'd0 : 32'd1);
        chk("r0.fifo_count", 32'(bus.fifo_count), 32'd0);

        // ---- random traffic vs model ----
        i = idle(); i.rst = 1'b1;
        step(i);
        chk_out("rnd.reset", m);
        for (int k = 0; k < 1500; k++) begin
            bit heavy;
            heavy = ((k / 100) % 2) == 1;
            i.rst          = ($urandom_range(0, 59) == 0);
            i.p_wen        = heavy ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 2) == 0);
            i.p_addr       = 4'($urandom_range(0, 15));
            i.p_data       = 16'($urandom);
            i.s_valid      = ($urandom_range(0, 1) == 1);
            i.s_addr       = 4'($urandom_range(0, 15));
            i.s_data       = 16'($urandom);
            i.s_issue      = ($urandom_range(0, 3) == 0);
            i.s_issue_addr = 4'($urandom_range(0, 15));
            step(i);
            chk_out($sformatf("rnd%0d", k), m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
